// File: rtl/pipearch_dma_read_arbiter.sv
// Round-robin arbiter sharing one CCI-P c0 read channel among N_CLIENTS DMA readers,
// with per-client credit limits and mdata client tagging. Optional stats: PIPEARCH_ARB_STATS_EN.
module pipearch_dma_read_arbiter #(
  parameter int N_CLIENTS       = 4,
  parameter int ADDR_W          = 42,
  parameter int DATA_W          = 512,
  parameter int USER_TAG_W      = 8,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           c0TxAlmFull,
  input  logic [1:0]                     vc_select,
  input  logic [N_CLIENTS-1:0]           cl_req_valid,
  input  logic [N_CLIENTS*ADDR_W-1:0]    cl_req_addr,
  input  logic [N_CLIENTS*USER_TAG_W-1:0] cl_req_tag,
  output logic [N_CLIENTS-1:0]           cl_req_ready,
  output logic [N_CLIENTS-1:0]           cl_rsp_valid,
  output logic [USER_TAG_W-1:0]          cl_rsp_tag,
  output logic [DATA_W-1:0]              cl_rsp_data,
  output logic                           tx_valid,
  output logic [ADDR_W-1:0]              tx_addr,
  output logic [1:0]                     tx_vc,
  output logic [15:0]                    tx_mdata,
  input  logic                           rx_valid,
  input  logic [15:0]                    rx_mdata,
  input  logic [DATA_W-1:0]              rx_data,
  output logic [1:0]                     err_sticky
`ifdef PIPEARCH_ARB_STATS_EN
  ,
  output logic [N_CLIENTS*32-1:0]        stat_grants,
  output logic [31:0]                    stat_almfull_cycles
`endif
);

  localparam int CLIENT_BITS = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W       = $clog2(MAX_OUTSTANDING) + 1;

  logic [CLIENT_BITS-1:0] rr_ptr, grant_id, ptr_next, rx_id;
  logic [N_CLIENTS-1:0]   eligible, grant, rx_hit, cnt_zero;
  logic                   grant_any, rx_known, underflow;
  logic [ADDR_W-1:0]      sel_addr;
  logic [USER_TAG_W-1:0]  sel_tag;
  logic [15:0]            mdata_next;
  logic [CNT_W-1:0]       outstanding [N_CLIENTS];
  logic                   unused_mdata;

  assign unused_mdata = ^rx_mdata;
  assign rx_id        = rx_mdata[CLIENT_BITS+USER_TAG_W-1:USER_TAG_W];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    eligible = '0;
    rx_hit   = '0;
    cnt_zero = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      eligible[i] = !reset && !c0TxAlmFull && cl_req_valid[i] &&
                    (outstanding[i] < CNT_W'(MAX_OUTSTANDING));
      rx_hit[i]   = rx_valid && (rx_id == CLIENT_BITS'(i));
      cnt_zero[i] = (outstanding[i] == '0);
    end
    rx_known  = |rx_hit;
    underflow = |(rx_hit & ~grant & cnt_zero);
  end

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    sel_addr  = '0;
    sel_tag   = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      idx = (int'(rr_ptr) + k) % N_CLIENTS;
      if (!grant_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        grant_any  = 1'b1;
        grant_id   = CLIENT_BITS'(idx);
        sel_addr   = cl_req_addr[idx*ADDR_W +: ADDR_W];
        sel_tag    = cl_req_tag[idx*USER_TAG_W +: USER_TAG_W];
      end
    end
  end

  always_comb begin
    mdata_next = '0;
    mdata_next[USER_TAG_W-1:0] = sel_tag;
    mdata_next[CLIENT_BITS+USER_TAG_W-1:USER_TAG_W] = grant_id;
    ptr_next = (int'(grant_id) == N_CLIENTS - 1) ? '0 : grant_id + CLIENT_BITS'(1);
  end

  assign cl_req_ready = grant;

  // NOTE: state updates use <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      tx_valid     <= 1'b0;
      tx_addr      <= '0;
      tx_vc        <= '0;
      tx_mdata     <= '0;
      cl_rsp_valid <= '0;
      cl_rsp_tag   <= '0;
      cl_rsp_data  <= '0;
      err_sticky   <= '0;
      // NOTE: the counters are credits, so the whole array is cleared; stale credits would block grants.
      for (int i = 0; i < N_CLIENTS; i++) outstanding[i] <= '0;
    end else begin
      tx_valid     <= grant_any;
      cl_rsp_valid <= rx_hit;
      if (grant_any) begin
        tx_addr  <= sel_addr;
        tx_vc    <= vc_select;
        tx_mdata <= mdata_next;
        rr_ptr   <= ptr_next;
      end
      if (rx_known) begin
        cl_rsp_tag  <= rx_mdata[USER_TAG_W-1:0];
        cl_rsp_data <= rx_data;
      end
      if (rx_valid && !rx_known) err_sticky[0] <= 1'b1;
      if (underflow)             err_sticky[1] <= 1'b1;
      for (int i = 0; i < N_CLIENTS; i++) begin
        case ({grant[i], rx_hit[i]})
          2'b10:   outstanding[i] <= outstanding[i] + CNT_W'(1);
          2'b01:   if (!cnt_zero[i]) outstanding[i] <= outstanding[i] - CNT_W'(1);
          default: outstanding[i] <= outstanding[i];
        endcase
      end
    end
  end

`ifdef PIPEARCH_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants         <= '0;
      stat_almfull_cycles <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++)
        if (grant[i]) stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
      if (c0TxAlmFull && |cl_req_valid) stat_almfull_cycles <= stat_almfull_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipearch_dma_read_arbiter.sv
// Bench for pipearch_dma_read_arbiter: a 4-client and a 3-client instance share stimulus and are
// compared each cycle against a transaction-level model of grants, credits and response routing.
module tb_pipearch_dma_read_arbiter;

  localparam int MAXO = 4;
  localparam int AW   = 42;
  localparam int DW   = 64;
  localparam int TW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, almfull, rx_valid;
  logic [1:0]    vc;
  logic [DW-1:0] rx_data;
  logic [3:0]    vld  [2];
  logic [15:0]   rxm  [2];
  logic [AW-1:0] addr [4];
  logic [TW-1:0] tag  [4];

  logic [4*AW-1:0] addr_bus_a;
  logic [3*AW-1:0] addr_bus_b;
  logic [4*TW-1:0] tag_bus_a;
  logic [3*TW-1:0] tag_bus_b;
  assign addr_bus_a = {addr[3], addr[2], addr[1], addr[0]};
  assign addr_bus_b = {addr[2], addr[1], addr[0]};
  assign tag_bus_a  = {tag[3], tag[2], tag[1], tag[0]};
  assign tag_bus_b  = {tag[2], tag[1], tag[0]};

  logic [3:0] ready_a, rspv_a;
  logic [2:0] ready_b, rspv_b;
  logic       txv_a, txv_b;
  logic [AW-1:0] txa_a, txa_b;
  logic [1:0]  txvc_a, txvc_b, err_a, err_b;
  logic [15:0] txm_a, txm_b;
  logic [TW-1:0] rtag_a, rtag_b;
  logic [DW-1:0] rdat_a, rdat_b;
`ifdef PIPEARCH_ARB_STATS_EN
  logic [4*32-1:0] sg_a;
  logic [3*32-1:0] sg_b;
  logic [31:0]     sa_a, sa_b;
`endif

  pipearch_dma_read_arbiter #(.N_CLIENTS(4), .ADDR_W(AW), .DATA_W(DW), .USER_TAG_W(TW),
                              .MAX_OUTSTANDING(MAXO)) dut_a (
    .clk(clk), .reset(reset), .c0TxAlmFull(almfull), .vc_select(vc),
    .cl_req_valid(vld[0]), .cl_req_addr(addr_bus_a), .cl_req_tag(tag_bus_a),
    .cl_req_ready(ready_a), .cl_rsp_valid(rspv_a), .cl_rsp_tag(rtag_a), .cl_rsp_data(rdat_a),
    .tx_valid(txv_a), .tx_addr(txa_a), .tx_vc(txvc_a), .tx_mdata(txm_a),
    .rx_valid(rx_valid), .rx_mdata(rxm[0]), .rx_data(rx_data), .err_sticky(err_a)
`ifdef PIPEARCH_ARB_STATS_EN
    , .stat_grants(sg_a), .stat_almfull_cycles(sa_a)
`endif
  );

  pipearch_dma_read_arbiter #(.N_CLIENTS(3), .ADDR_W(AW), .DATA_W(DW), .USER_TAG_W(TW),
                              .MAX_OUTSTANDING(MAXO)) dut_b (
    .clk(clk), .reset(reset), .c0TxAlmFull(almfull), .vc_select(vc),
    .cl_req_valid(vld[1][2:0]), .cl_req_addr(addr_bus_b), .cl_req_tag(tag_bus_b),
    .cl_req_ready(ready_b), .cl_rsp_valid(rspv_b), .cl_rsp_tag(rtag_b), .cl_rsp_data(rdat_b),
    .tx_valid(txv_b), .tx_addr(txa_b), .tx_vc(txvc_b), .tx_mdata(txm_b),
    .rx_valid(rx_valid), .rx_mdata(rxm[1]), .rx_data(rx_data), .err_sticky(err_b)
`ifdef PIPEARCH_ARB_STATS_EN
    , .stat_grants(sg_b), .stat_almfull_cycles(sa_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one entry per instance.
  int nc [2] = '{4, 3};
  int ptr [2];
  int cnt [2][4];
  logic [1:0]    m_err  [2];
  logic          e_txv  [2];
  logic [AW-1:0] e_addr [2];
  logic [15:0]   e_mdata[2];
  logic [1:0]    e_vc   [2];
  logic [3:0]    e_rspv [2];
  logic [TW-1:0] e_rtag [2];
  logic [DW-1:0] e_rdat [2];

  task automatic cycle();
    int g [2];
    int id, n;
    logic [3:0] act_rdy;
    #1;
    for (int u = 0; u < 2; u++) begin
      g[u] = -1;
      if (!reset && !almfull)
        for (int k = 0; k < nc[u]; k++) begin
          int i;
          i = (ptr[u] + k) % nc[u];
          if (g[u] < 0 && vld[u][i] && cnt[u][i] < MAXO) g[u] = i;
        end
      act_rdy = (u == 0) ? ready_a : {1'b0, ready_b};
      check($sformatf("ready[%0d]", u), 64'(act_rdy), (g[u] < 0) ? 64'd0 : 64'(1 << g[u]));
    end
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        ptr[u] = 0; m_err[u] = 2'b00; e_txv[u] = 1'b0; e_rspv[u] = 4'b0;
        for (int i = 0; i < 4; i++) cnt[u][i] = 0;
      end else begin
        e_txv[u] = (g[u] >= 0);
        if (g[u] >= 0) begin
          e_addr[u]  = addr[g[u]];
          e_mdata[u] = {6'b0, 2'(g[u]), tag[g[u]]};
          e_vc[u]    = vc;
          ptr[u]     = (g[u] + 1) % nc[u];
        end
        e_rspv[u] = 4'b0;
        id = int'(rxm[u][9:8]);
        if (rx_valid) begin
          if (id < nc[u]) begin
            e_rspv[u] = 4'(1 << id);
            e_rtag[u] = rxm[u][7:0];
            e_rdat[u] = rx_data;
          end else m_err[u][0] = 1'b1;
        end
        for (int i = 0; i < nc[u]; i++) begin
          n = cnt[u][i] + int'(g[u] == i) - int'(rx_valid && id == i);
          if (n < 0) begin n = 0; m_err[u][1] = 1'b1; end
          cnt[u][i] = n;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      logic a_txv;
      logic [AW-1:0] a_addr;
      logic [15:0] a_md;
      logic [1:0] a_vc, a_err;
      logic [3:0] a_rspv;
      logic [TW-1:0] a_rtag;
      logic [DW-1:0] a_rdat;
      if (u == 0) begin
        a_txv = txv_a; a_addr = txa_a; a_md = txm_a; a_vc = txvc_a; a_err = err_a;
        a_rspv = rspv_a; a_rtag = rtag_a; a_rdat = rdat_a;
      end else begin
        a_txv = txv_b; a_addr = txa_b; a_md = txm_b; a_vc = txvc_b; a_err = err_b;
        a_rspv = {1'b0, rspv_b}; a_rtag = rtag_b; a_rdat = rdat_b;
      end
      check($sformatf("tx_valid[%0d]", u), 64'(a_txv), 64'(e_txv[u]));
      if (e_txv[u]) begin
        check($sformatf("tx_addr[%0d]", u), 64'(a_addr), 64'(e_addr[u]));
        check($sformatf("tx_mdata[%0d]", u), 64'(a_md), 64'(e_mdata[u]));
        check($sformatf("tx_vc[%0d]", u), 64'(a_vc), 64'(e_vc[u]));
      end
      check($sformatf("rsp_valid[%0d]", u), 64'(a_rspv), 64'(e_rspv[u]));
      if (e_rspv[u] != 4'b0) begin
        check($sformatf("rsp_tag[%0d]", u), 64'(a_rtag), 64'(e_rtag[u]));
        check($sformatf("rsp_data[%0d]", u), a_rdat, e_rdat[u]);
      end
      check($sformatf("err_sticky[%0d]", u), 64'(a_err), 64'(m_err[u]));
    end
  endtask

  task automatic rand_req_fields();
    for (int i = 0; i < 4; i++) begin
      addr[i] = {10'($urandom), $urandom};
      tag[i]  = 8'($urandom);
    end
    vc = 2'($urandom);
  endtask

  task automatic set_valid(input logic [3:0] v);
    vld[0] = v;
    vld[1] = v;
  endtask

  task automatic set_rx(input logic v, input logic [15:0] md);
    rx_valid = v;
    rxm[0]   = md;
    rxm[1]   = md;
    rx_data  = {$urandom, $urandom};
  endtask

  initial begin
    reset = 1'b1; almfull = 1'b0;
    set_valid(4'b0);
    set_rx(1'b0, 16'h0);
    rand_req_fields();
    cycle(); cycle();
    reset = 1'b0;

    // All clients requesting: strict rotation 0,1,2,3,...
    set_valid(4'hF);
    repeat (8) begin rand_req_fields(); cycle(); end

    // Client 2 alone runs out of credits, then one response frees a credit.
    set_valid(4'b0100);
    repeat (4) begin rand_req_fields(); cycle(); end
    set_rx(1'b1, 16'h0205); cycle();
    set_rx(1'b0, 16'h0);    cycle(); cycle();

    // Almost-full window blocks client 1, released when it drops.
    set_valid(4'b0010);
    almfull = 1'b1;
    repeat (5) begin rand_req_fields(); cycle(); end
    almfull = 1'b0;
    cycle();

    // Client 0: grant and response in the same cycle.
    set_valid(4'b0001);
    rand_req_fields(); cycle();
    set_rx(1'b1, 16'h0033); rand_req_fields(); cycle();
    set_rx(1'b0, 16'h0); set_valid(4'b0); cycle();

    // Reset with many requests in flight, then stale and unknown-client responses.
    set_valid(4'hF);
    repeat (6) begin rand_req_fields(); cycle(); end
    reset = 1'b1; cycle();
    reset = 1'b0; set_valid(4'b0); cycle();
    set_rx(1'b1, 16'h03AA); cycle();
    set_rx(1'b1, 16'h0155); cycle();
    set_rx(1'b0, 16'h0);    cycle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rand_req_fields();
      vld[0]   = 4'($urandom);
      vld[1]   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : vld[0];
      almfull  = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 255) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = {$urandom, $urandom};
      for (int u = 0; u < 2; u++) begin
        int j;
        j = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(0, nc[u] - 1);
        rxm[u] = {6'($urandom), 2'(j), 8'($urandom)};
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
